// File: rtl/mac_ifm_feeder.sv
// MAC lane input-feature-map feeder: chunks a job into 64-element beats tagged with
// element-valid mask and inter/accum end flags. Optional build macro MAC_IFM_ZERO_MASK_EN.

package mac_pkg;
   localparam int MAC_W_ELEMENT = 9;
   localparam int MAC_N_ELEMENT = 64;

   typedef struct packed {
      logic [MAC_W_ELEMENT*MAC_N_ELEMENT-1:0] data;
      logic [MAC_N_ELEMENT-1:0]               data_element_valid;
      logic                                   inter_end;
      logic                                   accum_end;
   } mac_lane_ifm_port;
endpackage

module mac_ifm_feeder
   import mac_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [CNT_W-1:0]                cfg_chunk_num,
   input  logic [6:0]                      cfg_last_elem,
   input  logic [CNT_W-1:0]                cfg_inter_num,
   input  logic [CNT_W-1:0]                cfg_accum_num,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [MAC_W_ELEMENT*64-1:0]     in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output mac_lane_ifm_port                out_ifm,
   output logic                            busy,
   output logic                            done
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t            state;
   logic [CNT_W-1:0]  chunk_lim, inter_lim, accum_lim;
   logic [CNT_W-1:0]  chunk_cnt, inter_cnt, accum_cnt;
   logic [6:0]        last_elem;
   logic              last_chunk, last_inter, last_accum;
   logic              in_hs;
   mac_lane_ifm_port  beat_nxt;
   mac_lane_ifm_port  ifm_p0;
   logic              vld_p0;

   function automatic logic [CNT_W-1:0] eff_cnt(input logic [CNT_W-1:0] v);
      return (v == '0) ? CNT_W'(1) : v;
   endfunction

   function automatic logic [6:0] eff_last(input logic [6:0] v);
      return (v == 7'd0 || v > 7'd64) ? 7'd64 : v;
   endfunction

   function automatic logic [63:0] tail_mask(input logic [6:0] n);
      logic [63:0] m;
      for (int i = 0; i < 64; i++) begin
         m[i] = (7'(i) < n);
      end
      return m;
   endfunction

   function automatic logic [MAC_W_ELEMENT*64-1:0] zero_masked(
      input logic [MAC_W_ELEMENT*64-1:0] d,
      input logic [63:0]                 m
   );
      logic [MAC_W_ELEMENT*64-1:0] r;
      r = d;
      for (int i = 0; i < 64; i++) begin
         if (!m[i]) begin
            r[i*MAC_W_ELEMENT +: MAC_W_ELEMENT] = '0;
         end
      end
      return r;
   endfunction

   assign last_chunk = (chunk_cnt == chunk_lim - CNT_W'(1));
   assign last_inter = (inter_cnt == inter_lim - CNT_W'(1));
   assign last_accum = (accum_cnt == accum_lim - CNT_W'(1));

   assign in_ready = (state == RUN) & (~vld_p0 | out_ready);
   assign in_hs    = in_valid & in_ready;

   // Beat formed from the incoming chunk and the current loop position
   always_comb begin
      beat_nxt                    = '0;
      beat_nxt.data_element_valid = last_chunk ? tail_mask(last_elem) : '1;
      beat_nxt.inter_end          = last_chunk;
      beat_nxt.accum_end          = last_chunk & last_inter;
`ifdef MAC_IFM_ZERO_MASK_EN
      beat_nxt.data               = zero_masked(in_data, beat_nxt.data_element_valid);
`else
      beat_nxt.data               = in_data;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         chunk_lim <= CNT_W'(1);
         inter_lim <= CNT_W'(1);
         accum_lim <= CNT_W'(1);
         last_elem <= 7'd64;
         chunk_cnt <= '0;
         inter_cnt <= '0;
         accum_cnt <= '0;
         vld_p0    <= 1'b0;
         ifm_p0    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  chunk_lim <= eff_cnt(cfg_chunk_num);
                  inter_lim <= eff_cnt(cfg_inter_num);
                  accum_lim <= eff_cnt(cfg_accum_num);
                  last_elem <= eff_last(cfg_last_elem);
                  chunk_cnt <= '0;
                  inter_cnt <= '0;
                  accum_cnt <= '0;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (in_hs) begin
                  if (last_chunk) begin
                     chunk_cnt <= '0;
                     if (last_inter) begin
                        inter_cnt <= '0;
                        accum_cnt <= last_accum ? '0 : accum_cnt + CNT_W'(1);
                     end else begin
                        inter_cnt <= inter_cnt + CNT_W'(1);
                     end
                  end else begin
                     chunk_cnt <= chunk_cnt + CNT_W'(1);
                  end
                  if (last_chunk && last_inter && last_accum) begin
                     state <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (vld_p0 && out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Output register stage p0: a load may coincide with the drain of the held beat
         if (in_hs) begin
            ifm_p0 <= beat_nxt;
            vld_p0 <= 1'b1;
         end else if (out_ready) begin
            vld_p0 <= 1'b0;
         end
      end
   end

   assign out_ifm   = ifm_p0;
   assign out_valid = vld_p0;
   assign busy      = (state != IDLE);
   assign done      = (state == FLUSH) & vld_p0 & out_ready;

endmodule

// File: tb/tb_mac_ifm_feeder.sv
// Bench for mac_ifm_feeder: vector table of job configs driven with random data and
// stalls, checked beat-by-beat against an index-arithmetic model, plus reset-abort sequence.

module tb_mac_ifm_feeder;
   import mac_pkg::*;

   localparam int CNT_W = 16;
   localparam int DW    = MAC_W_ELEMENT * 64;
`ifdef MAC_IFM_ZERO_MASK_EN
   localparam bit ZERO_MASK = 1'b1;
`else
   localparam bit ZERO_MASK = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] cfg_chunk_num, cfg_inter_num, cfg_accum_num;
   logic [6:0]       cfg_last_elem;
   logic             in_valid, in_ready;
   logic [DW-1:0]    in_data;
   logic             out_valid, out_ready;
   mac_lane_ifm_port out_ifm;
   logic             busy, done;

   int checks   = 0;
   int failures = 0;
   logic [DW-1:0] last_data;
   logic [63:0]   last_mask_seen;

   typedef struct {
      int          chunk;
      int          last;
      int          inter;
      int          accum;
      int          omode;      // 0 always ready, 1 toggling 1010, 2 random
      int          imode;      // 0 always valid, 1 random
      int          dmode;      // 0 random data, 1 all 0x1FF
      int          exp_beats;
      logic [63:0] exp_last_mask;
   } vec_t;

   vec_t vecs[6];

   mac_ifm_feeder #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .cfg_chunk_num (cfg_chunk_num),
      .cfg_last_elem (cfg_last_elem),
      .cfg_inter_num (cfg_inter_num),
      .cfg_accum_num (cfg_accum_num),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_ifm       (out_ifm),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic int eff_cnt(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic int eff_last(input int v);
      return (v == 0 || v > 64) ? 64 : v;
   endfunction

   function automatic logic [63:0] low_mask(input int n);
      return (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
   endfunction

   function automatic logic [DW-1:0] exp_data(input logic [DW-1:0] d, input logic [63:0] m);
      logic [DW-1:0] r;
      r = d;
      for (int i = 0; i < 64; i++) begin
         if (ZERO_MASK && !m[i]) r[i*MAC_W_ELEMENT +: MAC_W_ELEMENT] = '0;
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_data(input int dmode);
      logic [DW-1:0] d;
      for (int i = 0; i < 64; i++) begin
         d[i*MAC_W_ELEMENT +: MAC_W_ELEMENT] = (dmode == 1) ? 9'h1FF : 9'($urandom);
      end
      return d;
   endfunction

   // Runs one job; expected beat k is derived from its position in the nested loop
   task automatic run_job(input vec_t v, input int id);
      int ch, il, le, total, k, sent, cyc;
      logic [DW-1:0] sent_q[$];
      logic prev_stall, done_seen;
      mac_lane_ifm_port prev_ifm;
      logic [63:0] emask;
      int c, ii;
      ch    = eff_cnt(v.chunk);
      il    = eff_cnt(v.inter);
      le    = eff_last(v.last);
      total = ch * il * eff_cnt(v.accum);
      k = 0; sent = 0; cyc = 0; prev_stall = 1'b0; done_seen = 1'b0; prev_ifm = '0;

      @(negedge clk);
      cfg_chunk_num = CNT_W'(v.chunk);
      cfg_last_elem = 7'(v.last);
      cfg_inter_num = CNT_W'(v.inter);
      cfg_accum_num = CNT_W'(v.accum);
      start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_busy_rise", id), 1024'(busy), 1024'(1));

      while (!done_seen && cyc < 2000) begin
         cfg_chunk_num = CNT_W'($urandom);
         cfg_last_elem = 7'($urandom);
         cfg_inter_num = CNT_W'($urandom);
         cfg_accum_num = CNT_W'($urandom);
         start     = 1'($urandom);
         in_valid  = (sent < total) && (v.imode == 0 || $urandom_range(0, 1) == 1);
         in_data   = rand_data(v.dmode);
         out_ready = (v.omode == 0) ? 1'b1 :
                     (v.omode == 1) ? (cyc % 2 == 0) : 1'($urandom);
         #1;
         if (prev_stall) begin
            chk($sformatf("v%0d_stall_valid", id), 1024'(out_valid), 1024'(1));
            chk($sformatf("v%0d_stall_hold", id), 1024'(out_ifm), 1024'(prev_ifm));
         end
         if (sent == total) chk($sformatf("v%0d_flush_in_ready", id), 1024'(in_ready), 1024'(0));
         if (out_valid && out_ready) begin
            c  = k % ch;
            ii = (k / ch) % il;
            emask = (c == ch - 1) ? low_mask(le) : {64{1'b1}};
            chk($sformatf("v%0d_b%0d_mask", id, k), 1024'(out_ifm.data_element_valid), 1024'(emask));
            chk($sformatf("v%0d_b%0d_inter_end", id, k), 1024'(out_ifm.inter_end), 1024'(c == ch - 1));
            chk($sformatf("v%0d_b%0d_accum_end", id, k), 1024'(out_ifm.accum_end),
                1024'(c == ch - 1 && ii == il - 1));
            if (k < sent) chk($sformatf("v%0d_b%0d_data", id, k), 1024'(out_ifm.data),
                              1024'(exp_data(sent_q[k], emask)));
            else chk($sformatf("v%0d_b%0d_unsent", id, k), 1024'(k), 1024'(sent));
            chk($sformatf("v%0d_b%0d_done", id, k), 1024'(done), 1024'(k == total - 1));
            last_data      = out_ifm.data;
            last_mask_seen = out_ifm.data_element_valid;
            k++;
            if (k == total) done_seen = 1'b1;
         end else if (done) begin
            chk($sformatf("v%0d_spurious_done", id), 1024'(done), 1024'(0));
         end
         if (in_valid && in_ready) begin
            sent_q.push_back(in_data);
            sent++;
         end
         prev_stall = out_valid && !out_ready;
         prev_ifm   = out_ifm;
         @(negedge clk);
         cyc++;
      end

      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      if (!done_seen) chk($sformatf("v%0d_timeout", id), 1024'(0), 1024'(1));
      chk($sformatf("v%0d_beat_count", id), 1024'(k), 1024'(v.exp_beats));
      chk($sformatf("v%0d_last_mask", id), 1024'(last_mask_seen), 1024'(v.exp_last_mask));
      chk($sformatf("v%0d_busy_fall", id), 1024'(busy), 1024'(0));
      chk($sformatf("v%0d_out_valid_idle", id), 1024'(out_valid), 1024'(0));
      chk($sformatf("v%0d_done_after", id), 1024'(done), 1024'(0));
   endtask

   initial begin
      vec_t rv;
      int   n;

      vecs[0] = '{3,   10, 2, 1, 0, 0, 0, 6, 64'h3FF};               // V1
      vecs[1] = '{1,   64, 1, 4, 0, 0, 0, 4, 64'hFFFF_FFFF_FFFF_FFFF}; // V2
      vecs[2] = '{3,   10, 2, 1, 1, 0, 0, 6, 64'h3FF};               // V3
      vecs[3] = '{0,    0, 0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF}; // V4
      vecs[4] = '{2,    5, 1, 1, 0, 0, 1, 2, 64'h1F};                // V6
      vecs[5] = '{2,  100, 1, 2, 2, 1, 0, 4, 64'hFFFF_FFFF_FFFF_FFFF}; // last>64

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      cfg_chunk_num = '0; cfg_last_elem = '0; cfg_inter_num = '0; cfg_accum_num = '0;
      last_data = '0; last_mask_seen = '0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 1024'(out_valid), 1024'(0));
      chk("rst_in_ready", 1024'(in_ready), 1024'(0));
      chk("rst_busy", 1024'(busy), 1024'(0));
      chk("rst_done", 1024'(done), 1024'(0));
      chk("rst_out_ifm", 1024'(out_ifm), 1024'(0));
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_job(vecs[i], i);
         if (i == 4) begin
            chk("v6_elem5", 1024'(last_data[5*MAC_W_ELEMENT +: MAC_W_ELEMENT]),
                1024'(ZERO_MASK ? 9'h000 : 9'h1FF));
            chk("v6_elem63", 1024'(last_data[63*MAC_W_ELEMENT +: MAC_W_ELEMENT]),
                1024'(ZERO_MASK ? 9'h000 : 9'h1FF));
            chk("v6_elem4", 1024'(last_data[4*MAC_W_ELEMENT +: MAC_W_ELEMENT]), 1024'(9'h1FF));
         end
      end

      // Abort with reset after the second beat, then restart the same job
      @(negedge clk);
      cfg_chunk_num = 16'd3; cfg_last_elem = 7'd10; cfg_inter_num = 16'd2; cfg_accum_num = 16'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      for (int cyc = 0; cyc < 50 && n < 2; cyc++) begin
         in_valid = 1'b1; in_data = rand_data(0); out_ready = 1'b1;
         #1;
         chk("v5_no_done", 1024'(done), 1024'(0));
         if (out_valid && out_ready) n++;
         @(negedge clk);
      end
      if (n < 2) chk("v5_timeout", 1024'(n), 1024'(2));
      rst = 1'b1;
      @(negedge clk);
      chk("v5_out_valid", 1024'(out_valid), 1024'(0));
      chk("v5_busy", 1024'(busy), 1024'(0));
      chk("v5_done", 1024'(done), 1024'(0));
      chk("v5_in_ready", 1024'(in_ready), 1024'(0));
      rst = 1'b0; in_valid = 1'b0;
      run_job(vecs[0], 10);

      for (int j = 0; j < 6; j++) begin
         rv.chunk = $urandom_range(0, 4);
         rv.last  = $urandom_range(0, 127);
         rv.inter = $urandom_range(0, 3);
         rv.accum = $urandom_range(0, 3);
         rv.omode = 2;
         rv.imode = 1;
         rv.dmode = 0;
         rv.exp_beats     = eff_cnt(rv.chunk) * eff_cnt(rv.inter) * eff_cnt(rv.accum);
         rv.exp_last_mask = low_mask(eff_last(rv.last));
         run_job(rv, 20 + j);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
